pc_branch_sequencer: RTL and testbench

- Owns the program counter and consumes branch/jump resolution from the pipeline.
- Takes the branch-taken flag (`Zero`) from the EX-stage branch comparator and the ID-stage jump decode, then redirects fetch and flushes wrong-path instructions.
- Holds a redirect until instruction memory accepts it when instruction memory is busy.
- Sits between the hazard unit, the EX-stage branch comparator and the instruction-fetch port.

---
 rtl/pc_branch_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_pc_branch_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_sequencer.sv
// Program counter owner: sequential fetch, branch/jump redirect, wrong-path flush.
// Optional branch statistics counters are built only when BRANCH_STATS_EN is defined.
module pc_branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STAT_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              FetchReady,
  input  logic              BranchValid,
  input  logic              Zero,
  input  logic [31:0]       BranchTarget,
  input  logic              JumpValid,
  input  logic [31:0]       JumpTarget,
  output logic [31:0]       PC,
  output logic [31:0]       PCPlus4,
  output logic              FlushIFID,
  output logic              FlushIDEX,
  output logic              Pending,
  output logic              AlignErr,
  output logic [STAT_W-1:0] BranchCount,
  output logic [STAT_W-1:0] TakenCount
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pend_target_r;
  logic [31:0] pend_target_next_s;
  logic        align_err_r;
  logic        align_err_next_s;
  logic        br_taken_s;
  logic        jmp_req_s;
  logic        redirect_s;
  logic [31:0] raw_target_s;
  logic [31:0] redirect_target_s;

  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Redirect requests; in PEND the pipeline inputs belong to the wrong path.
  always_comb begin
    br_taken_s = 1'b0;
    jmp_req_s  = 1'b0;
    if (state_r == RUN) begin
      br_taken_s = BranchValid & Zero;
      jmp_req_s  = JumpValid & ~(BranchValid & Zero);
    end else begin
      br_taken_s = 1'b0;
      jmp_req_s  = 1'b0;
    end
    redirect_s = br_taken_s | jmp_req_s;
    if (br_taken_s) begin
      raw_target_s = BranchTarget;
    end else begin
      raw_target_s = JumpTarget;
    end
    redirect_target_s = word_align(raw_target_s);
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (redirect_s && !FetchReady) begin
          state_next_s = PEND;
        end else begin
          state_next_s = RUN;
        end
      end
      PEND: begin
        if (FetchReady) begin
          state_next_s = RUN;
        end else begin
          state_next_s = PEND;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  // FSM outputs; flushes are Mealy and held low during reset.
  always_comb begin
    FlushIFID = 1'b0;
    FlushIDEX = 1'b0;
    Pending   = 1'b0;
    case (state_r)
      RUN: begin
        FlushIFID = redirect_s;
        FlushIDEX = br_taken_s;
        Pending   = 1'b0;
      end
      PEND: begin
        FlushIFID = 1'b1;
        FlushIDEX = 1'b0;
        Pending   = 1'b1;
      end
      default: begin
        FlushIFID = 1'b0;
        FlushIDEX = 1'b0;
        Pending   = 1'b0;
      end
    endcase
    if (Reset) begin
      FlushIFID = 1'b0;
      FlushIDEX = 1'b0;
    end else begin
      FlushIFID = FlushIFID;
      FlushIDEX = FlushIDEX;
    end
  end

  // PC, pending target and alignment-error next values.
  always_comb begin
    pc_next_s          = pc_r;
    pend_target_next_s = pend_target_r;
    align_err_next_s   = align_err_r;
    case (state_r)
      RUN: begin
        if (redirect_s) begin
          align_err_next_s = align_err_r | misaligned(raw_target_s);
          if (FetchReady) begin
            pc_next_s = redirect_target_s;
          end else begin
            pend_target_next_s = redirect_target_s;
          end
        end else if (!Stall && FetchReady) begin
          pc_next_s = pc_r + 32'd4;
        end else begin
          pc_next_s = pc_r;
        end
      end
      PEND: begin
        if (FetchReady) begin
          pc_next_s = pend_target_r;
        end else begin
          pc_next_s = pc_r;
        end
      end
      default: pc_next_s = pc_r;
    endcase
  end

  // PC datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_r          <= RESET_PC;
      pend_target_r <= 32'h0000_0000;
      align_err_r   <= 1'b0;
    end else begin
      pc_r          <= pc_next_s;
      pend_target_r <= pend_target_next_s;
      align_err_r   <= align_err_next_s;
    end
  end

  assign PC       = pc_r;
  assign PCPlus4  = pc_r + 32'd4;
  assign AlignErr = align_err_r;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] branch_cnt_r;
  logic [STAT_W-1:0] taken_cnt_r;

  // Branch statistics; only RUN cycles count, so wrong-path branches are excluded.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      branch_cnt_r <= {STAT_W{1'b0}};
      taken_cnt_r  <= {STAT_W{1'b0}};
    end else begin
      if (state_r == RUN && BranchValid) begin
        branch_cnt_r <= branch_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end else begin
        branch_cnt_r <= branch_cnt_r;
      end
      if (br_taken_s) begin
        taken_cnt_r <= taken_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end else begin
        taken_cnt_r <= taken_cnt_r;
      end
    end
  end

  assign BranchCount = branch_cnt_r;
  assign TakenCount  = taken_cnt_r;
`else
  assign BranchCount = {STAT_W{1'b0}};
  assign TakenCount  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed self-checking bench for pc_branch_sequencer (RESET_PC = 0x100).
module tb_pc_branch_sequencer;

  localparam int STAT_W = 16;

  logic              Clk;
  logic              Reset;
  logic              Stall;
  logic              FetchReady;
  logic              BranchValid;
  logic              Zero;
  logic [31:0]       BranchTarget;
  logic              JumpValid;
  logic [31:0]       JumpTarget;
  logic [31:0]       PC;
  logic [31:0]       PCPlus4;
  logic              FlushIFID;
  logic              FlushIDEX;
  logic              Pending;
  logic              AlignErr;
  logic [STAT_W-1:0] BranchCount;
  logic [STAT_W-1:0] TakenCount;

  int checks;
  int errors;

  pc_branch_sequencer #(.RESET_PC(32'h0000_0100), .STAT_W(STAT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .FetchReady(FetchReady),
    .BranchValid(BranchValid), .Zero(Zero), .BranchTarget(BranchTarget),
    .JumpValid(JumpValid), .JumpTarget(JumpTarget), .PC(PC), .PCPlus4(PCPlus4),
    .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX), .Pending(Pending),
    .AlignErr(AlignErr), .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic clear_redirects();
    BranchValid  = 1'b0;
    Zero         = 1'b0;
    JumpValid    = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Stall = 1'b0; FetchReady = 1'b0;
    BranchValid = 1'b1; Zero = 1'b1; BranchTarget = 32'h200;
    JumpValid = 1'b1; JumpTarget = 32'h400;
    @(negedge Clk); @(negedge Clk); #1;
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL reset_pc got %h exp %h", PC, 32'h100); end
    checks++; if (PCPlus4 !== 32'h104) begin errors++; $display("FAIL reset_pcplus4 got %h exp %h", PCPlus4, 32'h104); end
    checks++; if (Pending !== 1'b0 || AlignErr !== 1'b0) begin errors++; $display("FAIL reset_flags got pend=%b align=%b exp 0 0", Pending, AlignErr); end
    checks++; if (FlushIFID !== 1'b0 || FlushIDEX !== 1'b0) begin errors++; $display("FAIL reset_flush_forced got %b%b exp 00", FlushIFID, FlushIDEX); end
    checks++; if (BranchCount !== 16'd0 || TakenCount !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d %0d exp 0 0", BranchCount, TakenCount); end
    clear_redirects();
    Reset = 1'b0;
  endtask

  task automatic test_seq_fetch();
    FetchReady = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (PC !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, PC, 32'h100 + 32'(4 * i)); end
      checks++; if (FlushIFID !== 1'b0 || FlushIDEX !== 1'b0) begin errors++; $display("FAIL seq_flush%0d got %b%b exp 00", i, FlushIFID, FlushIDEX); end
    end
  endtask

  task automatic test_taken_branch();
    BranchValid = 1'b1; Zero = 1'b1; BranchTarget = 32'h200;
    #1;
    checks++; if (FlushIFID !== 1'b1 || FlushIDEX !== 1'b1) begin errors++; $display("FAIL br_flush got %b%b exp 11", FlushIFID, FlushIDEX); end
    tick(); clear_redirects();
    checks++; if (PC !== 32'h200) begin errors++; $display("FAIL br_pc got %h exp %h", PC, 32'h200); end
  endtask

  task automatic test_branch_beats_jump();
    BranchValid = 1'b1; Zero = 1'b1; BranchTarget = 32'h300;
    JumpValid = 1'b1; JumpTarget = 32'h400;
    #1;
    checks++; if (FlushIFID !== 1'b1 || FlushIDEX !== 1'b1) begin errors++; $display("FAIL brj_flush got %b%b exp 11", FlushIFID, FlushIDEX); end
    tick(); clear_redirects();
    checks++; if (PC !== 32'h300) begin errors++; $display("FAIL brj_pc got %h exp %h", PC, 32'h300); end
  endtask

  task automatic test_not_taken_and_jump();
    BranchValid = 1'b1; Zero = 1'b0; BranchTarget = 32'h700;
    #1;
    checks++; if (FlushIFID !== 1'b0 || FlushIDEX !== 1'b0) begin errors++; $display("FAIL nt_flush got %b%b exp 00", FlushIFID, FlushIDEX); end
    tick(); clear_redirects();
    checks++; if (PC !== 32'h304) begin errors++; $display("FAIL nt_pc got %h exp %h", PC, 32'h304); end
    JumpValid = 1'b1; JumpTarget = 32'h380;
    #1;
    checks++; if (FlushIFID !== 1'b1 || FlushIDEX !== 1'b0) begin errors++; $display("FAIL jmp_flush got %b%b exp 10", FlushIFID, FlushIDEX); end
    tick(); clear_redirects();
    checks++; if (PC !== 32'h380) begin errors++; $display("FAIL jmp_pc got %h exp %h", PC, 32'h380); end
  endtask

  task automatic test_hold();
    Stall = 1'b1; FetchReady = 1'b1;
    tick();
    checks++; if (PC !== 32'h380) begin errors++; $display("FAIL hold_stall got %h exp %h", PC, 32'h380); end
    Stall = 1'b0; FetchReady = 1'b0;
    tick();
    checks++; if (PC !== 32'h380) begin errors++; $display("FAIL hold_notready got %h exp %h", PC, 32'h380); end
  endtask

  task automatic test_pending();
    FetchReady = 1'b0; JumpValid = 1'b1; JumpTarget = 32'h500;
    #1;
    checks++; if (FlushIFID !== 1'b1 || FlushIDEX !== 1'b0 || Pending !== 1'b0) begin errors++; $display("FAIL pend_resolve got ifid=%b idex=%b pend=%b exp 1 0 0", FlushIFID, FlushIDEX, Pending); end
    tick(); clear_redirects();
    BranchValid = 1'b1; Zero = 1'b1; BranchTarget = 32'h900;
    JumpValid = 1'b1; JumpTarget = 32'h980; Stall = 1'b1;
    #1;
    checks++; if (Pending !== 1'b1 || FlushIFID !== 1'b1 || FlushIDEX !== 1'b0) begin errors++; $display("FAIL pend_c1 got pend=%b ifid=%b idex=%b exp 1 1 0", Pending, FlushIFID, FlushIDEX); end
    checks++; if (PC !== 32'h380) begin errors++; $display("FAIL pend_c1_pc got %h exp %h", PC, 32'h380); end
    tick(); clear_redirects(); Stall = 1'b0;
    checks++; if (Pending !== 1'b1 || FlushIFID !== 1'b1 || PC !== 32'h380) begin errors++; $display("FAIL pend_c2 got pend=%b ifid=%b pc=%h exp 1 1 380", Pending, FlushIFID, PC); end
    FetchReady = 1'b1;
    #1;
    checks++; if (Pending !== 1'b1 || FlushIFID !== 1'b1) begin errors++; $display("FAIL pend_c3 got pend=%b ifid=%b exp 1 1", Pending, FlushIFID); end
    tick();
    checks++; if (PC !== 32'h500 || Pending !== 1'b0 || FlushIFID !== 1'b0) begin errors++; $display("FAIL pend_release got pc=%h pend=%b ifid=%b exp 500 0 0", PC, Pending, FlushIFID); end
    tick();
    checks++; if (PC !== 32'h504) begin errors++; $display("FAIL pend_after got %h exp %h", PC, 32'h504); end
  endtask

  task automatic test_stall_override_align();
    Stall = 1'b1; BranchValid = 1'b1; Zero = 1'b1; BranchTarget = 32'h602;
    #1;
    checks++; if (FlushIFID !== 1'b1 || FlushIDEX !== 1'b1 || AlignErr !== 1'b0) begin errors++; $display("FAIL stall_br_flush got %b%b align=%b exp 11 0", FlushIFID, FlushIDEX, AlignErr); end
    tick(); clear_redirects();
    checks++; if (PC !== 32'h600 || AlignErr !== 1'b1) begin errors++; $display("FAIL stall_br_pc got pc=%h align=%b exp 600 1", PC, AlignErr); end
    Stall = 1'b0;
    tick();
    checks++; if (PC !== 32'h604 || AlignErr !== 1'b1) begin errors++; $display("FAIL align_sticky got pc=%h align=%b exp 604 1", PC, AlignErr); end
  endtask

  task automatic test_stats();
    logic [STAT_W-1:0] exp_br;
    logic [STAT_W-1:0] exp_tk;
`ifdef BRANCH_STATS_EN
    exp_br = 16'd4;
    exp_tk = 16'd3;
`else
    exp_br = 16'd0;
    exp_tk = 16'd0;
`endif
    checks++; if (BranchCount !== exp_br || TakenCount !== exp_tk) begin errors++; $display("FAIL stats got %0d %0d exp %0d %0d", BranchCount, TakenCount, exp_br, exp_tk); end
  endtask

  task automatic test_wrap();
    JumpValid = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    tick(); clear_redirects();
    checks++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got pc=%h p4=%h exp fffffffc 0", PC, PCPlus4); end
    tick();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", PC); end
  endtask

  task automatic test_reset_in_pend();
    FetchReady = 1'b0; JumpValid = 1'b1; JumpTarget = 32'h700;
    tick(); clear_redirects();
    checks++; if (Pending !== 1'b1 || AlignErr !== 1'b1) begin errors++; $display("FAIL rp_pre got pend=%b align=%b exp 1 1", Pending, AlignErr); end
    Reset = 1'b1;
    #1;
    checks++; if (PC !== 32'h100 || Pending !== 1'b0 || AlignErr !== 1'b0) begin errors++; $display("FAIL rp_async got pc=%h pend=%b align=%b exp 100 0 0", PC, Pending, AlignErr); end
    checks++; if (FlushIFID !== 1'b0 || FlushIDEX !== 1'b0 || BranchCount !== 16'd0 || TakenCount !== 16'd0) begin errors++; $display("FAIL rp_flush_cnt got %b%b %0d %0d exp 00 0 0", FlushIFID, FlushIDEX, BranchCount, TakenCount); end
    tick();
    Reset = 1'b0; FetchReady = 1'b1;
    tick();
    checks++; if (PC !== 32'h104 || Pending !== 1'b0) begin errors++; $display("FAIL rp_resume got pc=%h pend=%b exp 104 0", PC, Pending); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_seq_fetch();
    test_taken_branch();
    test_branch_beats_jump();
    test_not_taken_and_jump();
    test_hold();
    test_pending();
    test_stall_override_align();
    test_stats();
    test_wrap();
    test_reset_in_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
